// File: rtl/screen_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : screen_arbiter_pkg
// Brief   : FSM state encoding and default widths shared by the screen path.
// Revision: 1.0
// ============================================================================
package screen_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_COLOUR_WIDTH = 3;

endpackage
`default_nettype wire

// File: rtl/screen_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin pick: first set request at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               valid_o
);

  int cand;

  always_comb begin
    win_onehot_o = '0;
    win_idx_o    = '0;
    valid_o      = 1'b0;
    cand         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o            = 1'b1;
        win_idx_o          = IDX_W'(cand);
        win_onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/screen_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : screen_arbiter
// Brief   : Round-robin sharing of one screen_writer between drawing engines.
// Revision: 1.0
// ============================================================================
module screen_arbiter
  import screen_arbiter_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
  parameter int NUM_REQ      = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*WIDTH-1:0]        req_x_min,
  input  logic [NUM_REQ*WIDTH-1:0]        req_y_min,
  input  logic [NUM_REQ*WIDTH-1:0]        req_x_range,
  input  logic [NUM_REQ*WIDTH-1:0]        req_y_range,
  input  logic [NUM_REQ*COLOUR_WIDTH-1:0] req_colour,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            busy,
  output logic [WIDTH-1:0]                pix_x,
  output logic [WIDTH-1:0]                pix_y,
  output logic [COLOUR_WIDTH-1:0]         pix_old_colour,
  output logic                            screen_start,
  output logic [COLOUR_WIDTH-1:0]         new_screen_colour,
  output logic [WIDTH-1:0]                screen_x_min,
  output logic [WIDTH-1:0]                screen_y_min,
  output logic [WIDTH-1:0]                screen_x_range,
  output logic [WIDTH-1:0]                screen_y_range,
  input  logic [WIDTH-1:0]                screen_x,
  input  logic [WIDTH-1:0]                screen_y,
  input  logic [COLOUR_WIDTH-1:0]         old_screen_colour,
  input  logic                            screen_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SLOTS = 1 << IDX_W;

  // Per-requester views padded to a power of two so owner indexing is always in range.
  logic [WIDTH-1:0]        xmin_a [SLOTS];
  logic [WIDTH-1:0]        ymin_a [SLOTS];
  logic [WIDTH-1:0]        xrng_a [SLOTS];
  logic [WIDTH-1:0]        yrng_a [SLOTS];
  logic [COLOUR_WIDTH-1:0] col_a  [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_REQ) begin : g_used
      assign xmin_a[i] = req_x_min[i*WIDTH +: WIDTH];
      assign ymin_a[i] = req_y_min[i*WIDTH +: WIDTH];
      assign xrng_a[i] = req_x_range[i*WIDTH +: WIDTH];
      assign yrng_a[i] = req_y_range[i*WIDTH +: WIDTH];
      assign col_a[i]  = req_colour[i*COLOUR_WIDTH +: COLOUR_WIDTH];
    end else begin : g_pad
      assign xmin_a[i] = '0;
      assign ymin_a[i] = '0;
      assign xrng_a[i] = '0;
      assign yrng_a[i] = '0;
      assign col_a[i]  = '0;
    end
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   xmin_q, xmin_d, ymin_q, ymin_d;
  logic [WIDTH-1:0]   xrng_q, xrng_d, yrng_q, yrng_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .win_onehot_o (pick_onehot),
    .win_idx_o    (pick_idx),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      xmin_q  <= '0;
      ymin_q  <= '0;
      xrng_q  <= '0;
      yrng_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      xmin_q  <= xmin_d;
      ymin_q  <= ymin_d;
      xrng_q  <= xrng_d;
      yrng_q  <= yrng_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    xmin_d  = xmin_q;
    ymin_d  = ymin_q;
    xrng_d  = xrng_q;
    yrng_d  = yrng_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_START;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          xmin_d  = xmin_a[pick_idx];
          ymin_d  = ymin_a[pick_idx];
          xrng_d  = xrng_a[pick_idx];
          yrng_d  = yrng_a[pick_idx];
        end
      end
      // screen_done is deliberately ignored while the start pulse is out.
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (screen_done) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant             = grant_q;
  assign ack               = (state_q == S_ACK) ? grant_q : '0;
  assign busy              = (state_q != S_IDLE);
  assign screen_start      = (state_q == S_START);
  assign new_screen_colour = (state_q == S_BUSY) ? col_a[owner_q] : '0;
  assign screen_x_min      = xmin_q;
  assign screen_y_min      = ymin_q;
  assign screen_x_range    = xrng_q;
  assign screen_y_range    = yrng_q;
  assign pix_x             = screen_x;
  assign pix_y             = screen_y;
  assign pix_old_colour    = old_screen_colour;

endmodule
`default_nettype wire
